// File: rtl/code_lock_ctrl_pkg.sv
// rtl/code_lock_ctrl_pkg.sv - shared state enum, glyphs and defaults for the code lock
package code_lock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_OPEN    = 3'd1,
        ST_CLOSED  = 3'd2,
        ST_ERROR   = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_PROG    = 3'd5
    } lock_state_t;

    localparam int          DEF_CODE_LEN       = 6;
    localparam logic [23:0] DEF_CODE           = 24'h550245;
    localparam int          DEF_MAX_FAILS      = 3;
    localparam int          DEF_LOCKOUT_CYCLES = 1000;

    // Active-low seven-segment glyphs, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_S     = 7'h12;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_R     = 7'h2F;

    // Decimal numeral glyph; anything above 9 shows blank
    function automatic logic [6:0] seg_digit(input logic [3:0] v);
        case (v)
            4'd0:    seg_digit = 7'h40;
            4'd1:    seg_digit = 7'h79;
            4'd2:    seg_digit = 7'h24;
            4'd3:    seg_digit = 7'h30;
            4'd4:    seg_digit = 7'h19;
            4'd5:    seg_digit = 7'h12;
            4'd6:    seg_digit = 7'h02;
            4'd7:    seg_digit = 7'h78;
            4'd8:    seg_digit = 7'h00;
            4'd9:    seg_digit = 7'h10;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// rtl/code_lock_ctrl_if.sv - keypad/control inputs and status/display outputs of the code lock
interface code_lock_ctrl_if;

    logic       digit_valid;
    logic [3:0] digit;
    logic       clr;
    logic       prog_req;
    logic [2:0] status;
    logic [2:0] digit_idx;
    logic [1:0] fail_cnt;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output digit_valid, digit, clr, prog_req,
        input  status, digit_idx, fail_cnt,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  digit_valid, digit, clr, prog_req,
        output status, digit_idx, fail_cnt,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

endinterface

// File: rtl/lock_display.sv
// rtl/lock_display.sv - maps lock state and digit count onto six seven-segment glyphs
module lock_display
    import code_lock_ctrl_pkg::*;
(
    input  lock_state_t status,
    input  logic [2:0]  digit_idx,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    // Pick the word for the current state; unused positions stay blank
    always_comb begin
        hex0 = SEG_BLANK;
        hex1 = SEG_BLANK;
        hex2 = SEG_BLANK;
        hex3 = SEG_BLANK;
        hex4 = SEG_BLANK;
        hex5 = SEG_BLANK;
        case (status)
            ST_ENTRY: begin
                hex0 = seg_digit({1'b0, digit_idx});
            end
            ST_OPEN: begin
                hex3 = SEG_O;
                hex2 = SEG_P;
                hex1 = SEG_E;
                hex0 = SEG_N;
            end
            ST_CLOSED: begin
                hex5 = SEG_C;
                hex4 = SEG_L;
                hex3 = SEG_O;
                hex2 = SEG_S;
                hex1 = SEG_E;
                hex0 = SEG_D;
            end
            ST_ERROR: begin
                hex4 = SEG_E;
                hex3 = SEG_R;
                hex2 = SEG_R;
                hex1 = SEG_O;
                hex0 = SEG_R;
            end
            ST_LOCKOUT: begin
                hex5 = SEG_L;
                hex4 = SEG_O;
                hex3 = SEG_C;
            end
            ST_PROG: begin
                hex5 = SEG_P;
                hex0 = seg_digit({1'b0, digit_idx});
            end
            default: begin
                hex0 = SEG_BLANK;
            end
        endcase
    end

endmodule

// File: rtl/code_lock_ctrl.sv
// rtl/code_lock_ctrl.sv - BCD keypad code lock with lockout, reprogramming and registered display
module code_lock_ctrl
    import code_lock_ctrl_pkg::*;
#(
    parameter int                    CODE_LEN       = DEF_CODE_LEN,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = DEF_CODE,
    parameter int                    MAX_FAILS      = DEF_MAX_FAILS,
    parameter int                    LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    code_lock_ctrl_if.slave bus
);

    localparam int         CNT_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [2:0] LAST_IDX = 3'(CODE_LEN - 1);

    lock_state_t             state_q;
    logic [2:0]              idx_q;
    logic [1:0]              fail_q;
    logic                    mism_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [4*CODE_LEN-1:0]   active_q;
    logic [4*CODE_LEN-1:0]   staging_q;

    logic [3:0]              code_nib;
    logic                    mism_next;
    logic [1:0]              fail_inc;
    logic                    digit_legal;
    logic [4*CODE_LEN-1:0]   staged;

    logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5;
    logic [6:0] hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;

    // Digit compare and staging write both address the nibble at digit_idx, MS nibble first
    always_comb begin
        code_nib    = active_q[4*(CODE_LEN-1-int'(idx_q)) +: 4];
        digit_legal = (bus.digit <= 4'd9);
        mism_next   = mism_q | (bus.digit != code_nib);
        fail_inc    = fail_q + 2'd1;
        staged      = staging_q;
        staged[4*(CODE_LEN-1-int'(idx_q)) +: 4] = bus.digit;
    end

    // Main lock FSM; clr always takes priority over a same-cycle digit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ENTRY;
            idx_q     <= '0;
            fail_q    <= '0;
            mism_q    <= 1'b0;
            cnt_q     <= '0;
            active_q  <= DEFAULT_CODE;
            staging_q <= '0;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (bus.clr) begin
                        idx_q  <= '0;
                        mism_q <= 1'b0;
                    end else if (bus.digit_valid) begin
                        if (!digit_legal) begin
                            state_q <= ST_ERROR;
                        end else begin
                            mism_q <= mism_next;
                            idx_q  <= idx_q + 3'd1;
                            if (idx_q == LAST_IDX) begin
                                if (!mism_next) begin
                                    state_q <= ST_OPEN;
                                    fail_q  <= '0;
                                end else begin
                                    fail_q <= fail_inc;
                                    if (fail_inc == 2'(MAX_FAILS)) begin
                                        state_q <= ST_LOCKOUT;
                                        cnt_q   <= CNT_W'(LOCKOUT_CYCLES - 1);
                                    end else begin
                                        state_q <= ST_CLOSED;
                                    end
                                end
                            end
                        end
                    end
                end
                ST_CLOSED, ST_ERROR: begin
                    if (bus.clr) begin
                        state_q <= ST_ENTRY;
                        idx_q   <= '0;
                        mism_q  <= 1'b0;
                    end
                end
                ST_OPEN: begin
                    if (bus.clr) begin
                        state_q <= ST_ENTRY;
                        idx_q   <= '0;
                        mism_q  <= 1'b0;
                    end else if (bus.prog_req) begin
                        state_q <= ST_PROG;
                        idx_q   <= '0;
                    end
                end
                ST_PROG: begin
                    if (bus.clr) begin
                        state_q <= ST_OPEN;
                        idx_q   <= '0;
                    end else if (bus.digit_valid && digit_legal) begin
                        staging_q <= staged;
                        if (idx_q == LAST_IDX) begin
                            active_q <= staged;
                            state_q  <= ST_ENTRY;
                            idx_q    <= '0;
                            mism_q   <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_ENTRY;
                        fail_q  <= '0;
                        idx_q   <= '0;
                        mism_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_ENTRY;
                    idx_q   <= '0;
                    mism_q  <= 1'b0;
                end
            endcase
        end
    end

    lock_display u_display (
        .status    (state_q),
        .digit_idx (idx_q),
        .hex0      (disp0),
        .hex1      (disp1),
        .hex2      (disp2),
        .hex3      (disp3),
        .hex4      (disp4),
        .hex5      (disp5)
    );

    // Display register stage; trails the state register by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            hex0_q <= seg_digit(4'd0);
            hex1_q <= SEG_BLANK;
            hex2_q <= SEG_BLANK;
            hex3_q <= SEG_BLANK;
            hex4_q <= SEG_BLANK;
            hex5_q <= SEG_BLANK;
        end else begin
            hex0_q <= disp0;
            hex1_q <= disp1;
            hex2_q <= disp2;
            hex3_q <= disp3;
            hex4_q <= disp4;
            hex5_q <= disp5;
        end
    end

    assign bus.status    = state_q;
    assign bus.digit_idx = idx_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.HEX0      = hex0_q;
    assign bus.HEX1      = hex1_q;
    assign bus.HEX2      = hex2_q;
    assign bus.HEX3      = hex3_q;
    assign bus.HEX4      = hex4_q;
    assign bus.HEX5      = hex5_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb/tb_code_lock_ctrl.sv - scoreboard bench for the code lock controller
module tb_code_lock_ctrl;

    localparam logic [6:0] B   = 7'h7F;
    localparam logic [6:0] G_O = 7'h40;
    localparam logic [6:0] G_P = 7'h0C;
    localparam logic [6:0] G_E = 7'h06;
    localparam logic [6:0] G_N = 7'h2B;
    localparam logic [6:0] G_C = 7'h46;
    localparam logic [6:0] G_L = 7'h47;
    localparam logic [6:0] G_S = 7'h12;
    localparam logic [6:0] G_D = 7'h21;
    localparam logic [6:0] G_R = 7'h2F;

    localparam logic [41:0] HX_OPEN   = {B, B, G_O, G_P, G_E, G_N};
    localparam logic [41:0] HX_CLOSED = {G_C, G_L, G_O, G_S, G_E, G_D};
    localparam logic [41:0] HX_ERR    = {B, G_E, G_R, G_R, G_O, G_R};
    localparam logic [41:0] HX_LOC    = {G_L, G_O, G_C, B, B, B};

    localparam logic [2:0] S_ENTRY = 3'd0, S_OPEN = 3'd1, S_CLOSED = 3'd2;
    localparam logic [2:0] S_ERROR = 3'd3, S_LOCK = 3'd4, S_PROG = 3'd5;

    // mask bits: [0] status, [1] digit_idx, [2] fail_cnt, [3] displays
    localparam logic [3:0] M_ALL   = 4'b1111;
    localparam logic [3:0] M_NOIDX = 4'b1101;
    localparam logic [3:0] M_STIF  = 4'b0111;
    localparam logic [3:0] M_ST    = 4'b0001;

    typedef struct packed {
        int          due;
        logic [3:0]  mask;
        logic [2:0]  st;
        logic [2:0]  ix;
        logic [1:0]  fc;
        logic [41:0] hx;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vec_cnt = 0;
    int   miss_cnt = 0;

    exp_t  exp_q[$];
    string name_q[$];

    code_lock_ctrl_if bus ();

    code_lock_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] dg(input int n);
        case (n)
            0: dg = 7'h40;
            1: dg = 7'h79;
            2: dg = 7'h24;
            3: dg = 7'h30;
            4: dg = 7'h19;
            5: dg = 7'h12;
            6: dg = 7'h02;
            default: dg = 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] hx_entry(input int n);
        hx_entry = {B, B, B, B, B, dg(n)};
    endfunction

    function automatic logic [41:0] hx_prog(input int n);
        hx_prog = {G_P, B, B, B, B, dg(n)};
    endfunction

    // Monitor: pops every expectation that has come due and compares it with the DUT outputs
    exp_t        mon_e;
    string       mon_n;
    logic        mon_bad;
    logic [41:0] mon_hx;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e   = exp_q.pop_front();
            mon_n   = name_q.pop_front();
            mon_hx  = {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
            mon_bad = 1'b0;
            vec_cnt++;
            if (mon_e.mask[0] && bus.status    !== mon_e.st) mon_bad = 1'b1;
            if (mon_e.mask[1] && bus.digit_idx !== mon_e.ix) mon_bad = 1'b1;
            if (mon_e.mask[2] && bus.fail_cnt  !== mon_e.fc) mon_bad = 1'b1;
            if (mon_e.mask[3] && mon_hx        !== mon_e.hx) mon_bad = 1'b1;
            if (mon_bad) begin
                miss_cnt++;
                $display("FAIL %s @%0d: got status=%0d idx=%0d fail=%0d hex=%h, want status=%0d idx=%0d fail=%0d hex=%h (mask %b)",
                         mon_n, cyc, bus.status, bus.digit_idx, bus.fail_cnt, mon_hx,
                         mon_e.st, mon_e.ix, mon_e.fc, mon_e.hx, mon_e.mask);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string nm, input int dly, input logic [3:0] mask,
                            input logic [2:0] st, input logic [2:0] ix,
                            input logic [1:0] fc, input logic [41:0] hx);
        exp_t e;
        e.due  = cyc + dly;
        e.mask = mask;
        e.st   = st;
        e.ix   = ix;
        e.fc   = fc;
        e.hx   = hx;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Expect a settled state (displays included) one cycle from now, then idle past it
    task automatic chk(input string nm, input logic [3:0] mask, input logic [2:0] st,
                       input logic [2:0] ix, input logic [1:0] fc, input logic [41:0] hx);
        push_exp(nm, 1, mask, st, ix, fc, hx);
        step();
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        step();
        bus.digit_valid = 1'b0;
    endtask

    task automatic send_code(input logic [23:0] c);
        for (int i = 0; i < 6; i++) send_digit(c[4*(5-i) +: 4]);
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    task automatic pulse_prog();
        bus.prog_req = 1'b1;
        step();
        bus.prog_req = 1'b0;
    endtask

    logic [3:0] ok_code[6];
    int         c0;

    initial begin
        ok_code = '{4'd5, 4'd5, 4'd0, 4'd2, 4'd4, 4'd5};
        reset           = 1'b1;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.clr         = 1'b0;
        bus.prog_req    = 1'b0;
        do_reset();
        chk("reset", M_ALL, S_ENTRY, 3'd0, 2'd0, hx_entry(0));

        // correct default code, with a look at the partial entry
        send_digit(4'd5); send_digit(4'd5); send_digit(4'd0);
        chk("partial3", M_ALL, S_ENTRY, 3'd3, 2'd0, hx_entry(3));
        send_digit(4'd2); send_digit(4'd4); send_digit(4'd5);
        chk("open_default", M_NOIDX, S_OPEN, 3'd0, 2'd0, HX_OPEN);
        pulse_clr();
        chk("relock", M_ALL, S_ENTRY, 3'd0, 2'd0, hx_entry(0));

        // wrong first digit
        send_code(24'h450245);
        chk("closed", M_NOIDX, S_CLOSED, 3'd0, 2'd1, HX_CLOSED);
        send_digit(4'd5);
        pulse_prog();
        chk("closed_ignores", M_NOIDX, S_CLOSED, 3'd0, 2'd1, HX_CLOSED);
        pulse_clr();
        chk("closed_clr", M_ALL, S_ENTRY, 3'd0, 2'd1, hx_entry(0));

        // illegal digit straight after reset
        do_reset();
        send_digit(4'd10);
        push_exp("error_next_cycle", 0, M_STIF, S_ERROR, 3'd0, 2'd0, '0);
        chk("error", M_ALL, S_ERROR, 3'd0, 2'd0, HX_ERR);
        pulse_clr();
        chk("error_clr", M_ALL, S_ENTRY, 3'd0, 2'd0, hx_entry(0));

        // illegal digit mid-entry keeps digit_idx
        send_digit(4'd5); send_digit(4'd5);
        send_digit(4'd12);
        chk("error_mid", M_ALL, S_ERROR, 3'd2, 2'd0, HX_ERR);
        pulse_clr();

        // three wrong codes -> lockout
        send_code(24'h111111);
        chk("fail1", M_NOIDX, S_CLOSED, 3'd0, 2'd1, HX_CLOSED);
        pulse_clr();
        send_code(24'h551245);
        chk("fail2", M_NOIDX, S_CLOSED, 3'd0, 2'd2, HX_CLOSED);
        pulse_clr();
        send_code(24'h550246);
        c0 = cyc;
        push_exp("lock_enter",  0,    M_STIF & 4'b0101, S_LOCK, 3'd0, 2'd3, '0);
        push_exp("lock_disp",   1,    M_NOIDX, S_LOCK, 3'd0, 2'd3, HX_LOC);
        push_exp("lock_mid",    500,  M_NOIDX, S_LOCK, 3'd0, 2'd3, HX_LOC);
        push_exp("lock_last",   999,  M_ST,    S_LOCK, 3'd0, 2'd3, '0);
        push_exp("lock_exit",   1000, M_STIF,  S_ENTRY, 3'd0, 2'd0, '0);
        push_exp("lock_exit_d", 1001, M_ALL,   S_ENTRY, 3'd0, 2'd0, hx_entry(0));
        for (int i = 0; i < 990; i++) begin
            bus.digit_valid = 1'b1;
            bus.digit       = ok_code[i % 6];
            bus.clr         = ((i % 97) == 5);
            bus.prog_req    = ((i % 61) == 7);
            step();
        end
        bus.digit_valid = 1'b0;
        bus.clr         = 1'b0;
        bus.prog_req    = 1'b0;
        while (cyc < c0 + 1003) step();

        // program a new code
        send_code(24'h550245);
        chk("open_after_lock", M_NOIDX, S_OPEN, 3'd0, 2'd0, HX_OPEN);
        pulse_prog();
        chk("prog_enter", M_ALL, S_PROG, 3'd0, 2'd0, hx_prog(0));
        send_digit(4'd1); send_digit(4'd2); send_digit(4'd3);
        chk("prog3", M_ALL, S_PROG, 3'd3, 2'd0, hx_prog(3));
        send_digit(4'd11);
        chk("prog_illegal", M_ALL, S_PROG, 3'd3, 2'd0, hx_prog(3));
        send_digit(4'd4); send_digit(4'd5); send_digit(4'd6);
        chk("prog_done", M_ALL, S_ENTRY, 3'd0, 2'd0, hx_entry(0));
        send_code(24'h550245);
        chk("old_code_rejected", M_NOIDX, S_CLOSED, 3'd0, 2'd1, HX_CLOSED);
        pulse_clr();
        send_code(24'h123456);
        chk("new_code_opens", M_NOIDX, S_OPEN, 3'd0, 2'd0, HX_OPEN);

        // programmed code is lost on reset
        do_reset();
        send_code(24'h123456);
        chk("new_code_after_reset", M_NOIDX, S_CLOSED, 3'd0, 2'd1, HX_CLOSED);
        pulse_clr();
        send_code(24'h550245);
        chk("default_after_reset", M_NOIDX, S_OPEN, 3'd0, 2'd0, HX_OPEN);

        // abort programming with clr colliding with a digit
        pulse_prog();
        send_digit(4'd7); send_digit(4'd7); send_digit(4'd7);
        bus.clr = 1'b1;
        send_digit(4'd7);
        bus.clr = 1'b0;
        chk("prog_abort", M_NOIDX, S_OPEN, 3'd0, 2'd0, HX_OPEN);
        pulse_clr();
        send_code(24'h550245);
        chk("old_code_kept", M_NOIDX, S_OPEN, 3'd0, 2'd0, HX_OPEN);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            miss_cnt++;
            $display("FAIL drain: %0d expectations never came due, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
